// File: rtl/enc_pkg.sv
// Shared definitions for the event encoder: FSM state type, default line
// count and a width helper that never returns zero.
package enc_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    localparam int ENC_N_DEFAULT = 8;

    // Index width for n lines, at least one bit even for degenerate n.
    function automatic int clog2_safe(input int n);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/enc_prio_pick.sv
// Combinational priority picker. Scans vec_i starting at start_i with
// wraparound, upward or downward, and reports the first set bit as a binary
// index, a one-hot mask and an any flag. Tying start_i to N-1 with a
// downward scan gives plain highest-index-wins priority.
module enc_prio_pick
    import enc_pkg::*;
#(
    parameter int N      = ENC_N_DEFAULT,
    parameter int IDX_W  = clog2_safe(N),
    parameter bit UPWARD = 1'b1
) (
    input  logic [N-1:0]     vec_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o,
    output logic             any_o
);

    // Walk the rotated search order and keep the first hit.
    always_comb begin
        int  pos;
        logic found;
        pos      = 0;
        found    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (UPWARD) begin
                pos = (int'(start_i) + i) % N;
            end else begin
                pos = (int'(start_i) - i + N) % N;
            end
            if (!found && vec_i[pos]) begin
                found         = 1'b1;
                idx_o         = pos[IDX_W-1:0];
                onehot_o[pos] = 1'b1;
            end else begin
                found = found;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/event_encoder.sv
// Event encoder: captures N request lines into a sticky pending register
// and hands out one encoded index at a time over a valid/ready handshake.
// Build option: define ENC_ROUND_ROBIN_EN for round-robin selection starting
// after the last accepted index; otherwise the highest pending index wins.
module event_encoder
    import enc_pkg::*;
#(
    parameter int N    = ENC_N_DEFAULT,
    parameter int EDGE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req,
    output logic [clog2_safe(N)-1:0]  out_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              pending,
    output logic                      overflow
);

    localparam int IDX_W = clog2_safe(N);

    state_e           state_q;
    logic [N-1:0]     req_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     pending_d;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_valid_q;
    logic             overflow_q;
    logic             overflow_d;

    logic [N-1:0]     cap_s;
    logic [N-1:0]     take_s;
    logic             handshake_s;
    logic             load_s;
    logic [IDX_W-1:0] pick_start_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [N-1:0]     pick_onehot_s;
    logic             pick_any_s;

    assign handshake_s = out_valid_q & out_ready;

`ifdef ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_base_s;

    // Search begins just past the most recently accepted index; on an
    // accepting cycle that is the index leaving the output right now.
    always_comb begin
        rr_base_s = handshake_s ? out_idx_q : rr_ptr_q;
        if (rr_base_s == IDX_W'(N - 1)) begin
            pick_start_s = '0;
        end else begin
            pick_start_s = rr_base_s + IDX_W'(1);
        end
    end

    // Remember the last accepted index; reset points just before index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= IDX_W'(N - 1);
        end else if (handshake_s) begin
            rr_ptr_q <= out_idx_q;
        end else begin
            rr_ptr_q <= rr_ptr_q;
        end
    end

    enc_prio_pick #(
        .N      (N),
        .IDX_W  (IDX_W),
        .UPWARD (1'b1)
    ) u_pick (
        .vec_i    (pending_q),
        .start_i  (pick_start_s),
        .idx_o    (pick_idx_s),
        .onehot_o (pick_onehot_s),
        .any_o    (pick_any_s)
    );
`else
    assign pick_start_s = IDX_W'(N - 1);

    enc_prio_pick #(
        .N      (N),
        .IDX_W  (IDX_W),
        .UPWARD (1'b0)
    ) u_pick (
        .vec_i    (pending_q),
        .start_i  (pick_start_s),
        .idx_o    (pick_idx_s),
        .onehot_o (pick_onehot_s),
        .any_o    (pick_any_s)
    );
`endif

    // Capture, take and overflow: only registered pending is eligible for
    // selection, and a same-cycle capture keeps a taken bit pending.
    always_comb begin
        if (EDGE != 0) begin
            cap_s = req & ~req_q;
        end else begin
            cap_s = req;
        end
        if (state_q == IDLE) begin
            load_s = pick_any_s;
        end else begin
            load_s = pick_any_s & handshake_s;
        end
        if (load_s) begin
            take_s = pick_onehot_s;
        end else begin
            take_s = '0;
        end
        pending_d  = (pending_q & ~take_s) | cap_s;
        overflow_d = |(cap_s & pending_q & ~take_s);
    end

    // Pending/overflow registers and the IDLE/PRESENT output FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            req_q      <= req;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            case (state_q)
                IDLE: begin
                    if (pick_any_s) begin
                        out_idx_q   <= pick_idx_s;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end else begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                PRESENT: begin
                    if (handshake_s) begin
                        if (pick_any_s) begin
                            out_idx_q   <= pick_idx_s;
                            out_valid_q <= 1'b1;
                            state_q     <= PRESENT;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder: a level-capture instance and an
// edge-capture instance share clock and reset; every step checks outputs
// against hand-computed values with immediate assertions.
module tb_event_encoder;

`ifdef ENC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_l, req_e;
    logic       rdy_l, rdy_e;
    logic [2:0] idx_l, idx_e;
    logic       vld_l, vld_e;
    logic [7:0] pend_l, pend_e;
    logic       ovf_l, ovf_e;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    event_encoder #(.N(8), .EDGE(0)) dut_lvl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_l),
        .out_idx   (idx_l),
        .out_valid (vld_l),
        .out_ready (rdy_l),
        .pending   (pend_l),
        .overflow  (ovf_l)
    );

    event_encoder #(.N(8), .EDGE(1)) dut_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_e),
        .out_idx   (idx_e),
        .out_valid (vld_e),
        .out_ready (rdy_e),
        .pending   (pend_e),
        .overflow  (ovf_e)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_l = 8'h00; rdy_l = 1'b0;
        req_e = 8'h00; rdy_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_l", 32'(vld_l), 32'd0);
        check("rst_idx_l", 32'(idx_l), 32'd0);
        check("rst_pend_l", 32'(pend_l), 32'd0);
        check("rst_ovf_l", 32'(ovf_l), 32'd0);
        check("rst_valid_e", 32'(vld_e), 32'd0);
        check("rst_pend_e", 32'(pend_e), 32'd0);
        rst_n = 1'b1;

        // All lines held high in level mode.
        req_l = 8'hFF; rdy_l = 1'b1;
        tick();
        check("ff_cap_valid", 32'(vld_l), 32'd0);
        check("ff_cap_pend", 32'(pend_l), 32'h0000_00FF);
        tick();
        check("ff_first_valid", 32'(vld_l), 32'd1);
        check("ff_first_idx", 32'(idx_l), RR ? 32'd0 : 32'd7);
        check("ff_ovf", 32'(ovf_l), 32'd1);
        for (int k = 1; k < 9; k++) begin
            tick();
            check("ff_seq_idx", 32'(idx_l), RR ? 32'(k % 8) : 32'd7);
            check("ff_seq_valid", 32'(vld_l), 32'd1);
        end

        // Asynchronous reset between clock edges while presenting.
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(vld_l), 32'd0);
        check("arst_pend", 32'(pend_l), 32'd0);
        check("arst_ovf", 32'(ovf_l), 32'd0);
        check("arst_idx", 32'(idx_l), 32'd0);
        req_l = 8'h00; rdy_l = 1'b0;
        tick();
        rst_n = 1'b1;
        req_l = 8'h02; rdy_l = 1'b1;
        tick();
        check("post_rst_lat1_valid", 32'(vld_l), 32'd0);
        check("post_rst_lat1_pend", 32'(pend_l), 32'h0000_0002);
        req_l = 8'h00;
        tick();
        check("post_rst_lat2_valid", 32'(vld_l), 32'd1);
        check("post_rst_lat2_idx", 32'(idx_l), 32'd1);
        tick();
        check("post_rst_done", 32'(vld_l), 32'd0);

        // Two lines pulsed for one cycle, consumer always ready.
        req_l = 8'h48;
        tick();
        check("p48_cap_valid", 32'(vld_l), 32'd0);
        check("p48_cap_pend", 32'(pend_l), 32'h0000_0048);
        req_l = 8'h00;
        tick();
        check("p48_first_idx", 32'(idx_l), RR ? 32'd3 : 32'd6);
        check("p48_first_valid", 32'(vld_l), 32'd1);
        check("p48_first_pend", 32'(pend_l), RR ? 32'h0000_0040 : 32'h0000_0008);
        tick();
        check("p48_second_idx", 32'(idx_l), RR ? 32'd6 : 32'd3);
        check("p48_second_valid", 32'(vld_l), 32'd1);
        check("p48_second_pend", 32'(pend_l), 32'd0);
        tick();
        check("p48_end_valid", 32'(vld_l), 32'd0);
        check("p48_end_pend", 32'(pend_l), 32'd0);
        check("p48_end_ovf", 32'(ovf_l), 32'd0);

        // Backpressure: held stable for five cycles, then one handshake.
        rdy_l = 1'b0; req_l = 8'h04;
        tick();
        req_l = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_idx", 32'(idx_l), 32'd2);
            check("bp_valid", 32'(vld_l), 32'd1);
        end
        rdy_l = 1'b1;
        tick();
        check("bp_release_valid", 32'(vld_l), 32'd0);

        // Edge mode overflow on bit 5 while bit 6 is presented.
        rdy_e = 1'b0; req_e = 8'h40;
        tick();
        req_e = 8'h00;
        tick();
        check("ov_pres_idx", 32'(idx_e), 32'd6);
        check("ov_pres_valid", 32'(vld_e), 32'd1);
        req_e = 8'h20;
        tick();
        check("ov_cap1_pend", 32'(pend_e), 32'h0000_0020);
        check("ov_cap1_ovf", 32'(ovf_e), 32'd0);
        req_e = 8'h00;
        tick();
        check("ov_low_ovf", 32'(ovf_e), 32'd0);
        req_e = 8'h20;
        tick();
        check("ov_pulse", 32'(ovf_e), 32'd1);
        check("ov_pulse_pend", 32'(pend_e), 32'h0000_0020);
        tick();
        check("ov_pulse_end", 32'(ovf_e), 32'd0);
        rdy_e = 1'b1; req_e = 8'h00;
        tick();
        check("ov_b5_idx", 32'(idx_e), 32'd5);
        check("ov_b5_valid", 32'(vld_e), 32'd1);
        check("ov_b5_pend", 32'(pend_e), 32'd0);
        tick();
        check("ov_once_valid", 32'(vld_e), 32'd0);
        tick();
        check("ov_idle_valid", 32'(vld_e), 32'd0);
        check("ov_idle_ovf", 32'(ovf_e), 32'd0);

        // Capture of bit 4 in the same cycle bit 4 is loaded.
        rdy_e = 1'b0; req_e = 8'h40;
        tick();
        req_e = 8'h00;
        tick();
        check("ct_pres_idx", 32'(idx_e), 32'd6);
        req_e = 8'h10;
        tick();
        check("ct_cap_pend", 32'(pend_e), 32'h0000_0010);
        req_e = 8'h00;
        tick();
        rdy_e = 1'b1; req_e = 8'h10;
        tick();
        check("ct_first_idx", 32'(idx_e), 32'd4);
        check("ct_first_pend", 32'(pend_e), 32'h0000_0010);
        check("ct_first_ovf", 32'(ovf_e), 32'd0);
        req_e = 8'h00;
        tick();
        check("ct_second_idx", 32'(idx_e), 32'd4);
        check("ct_second_valid", 32'(vld_e), 32'd1);
        check("ct_second_ovf", 32'(ovf_e), 32'd0);
        check("ct_second_pend", 32'(pend_e), 32'd0);
        tick();
        check("ct_end_valid", 32'(vld_e), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Parametrised, sequential successor to the team's fixed 8:3 encoder.
- Captures N request lines into a sticky pending register and encodes the highest-priority pending request to a binary index.
- Presents each index once over a valid/ready handshake.
- Sits between raw event/interrupt sources and a single consumer (controller or sequencer).

Parameters:
- N, 8, number of request lines (>= 2).
- EDGE, 0, 0 = level capture (req high sets pending every cycle); 1 = rising-edge capture only.
- IDX_W (derived localparam, not overridable), $clog2(N), index width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request lines; bit k = source k.
- out_idx  output  IDX_W  encoded index of presented request.
- out_valid  output  1  out_idx holds an unconsumed event.
- out_ready  input  1  consumer accepts; handshake = out_valid & out_ready.
- pending  output  N  current pending register (excludes the presented event).
- overflow  output  1  one-cycle pulse: a capture hit an already-pending bit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All registers are cleared immediately on rst_n low, independent of clk.
- Reset values: pending = 0, req_q = 0, out_valid = 0, out_idx = 0, overflow = 0, state = IDLE, rr_ptr = N-1.
- Capture:
  - cap = EDGE ? (req & ~req_q) : req; req_q <= req every cycle.
  - pending_next = (pending & ~take) | cap, where take = one-hot of the bit being loaded to the output this cycle.
  - Capture wins over take on the same bit: the bit stays pending and is re-presented later.
- Overflow: overflow <= |(cap & pending & ~take); registered, pulses exactly one cycle. Merged events are lost.
- Priority (default): highest index wins; req[N-1] is highest. Result in out_idx is the binary index.
- FSM, two states:
  - IDLE: out_valid = 0. If pending != 0: load out_idx = pick(pending), take = that bit, go to PRESENT. Else stay.
  - PRESENT: out_valid = 1; out_idx and out_valid held stable until handshake.
  - On handshake with pending != 0: load next pick in the same cycle and stay in PRESENT (back-to-back, 1 event/cycle).
  - On handshake with pending == 0: go to IDLE, out_valid = 0.
- Selection uses the registered pending only; same-cycle captures are not eligible.
- Latency: req high at edge t -> pending bit set after t -> out_valid high after edge t+1 (2 cycles) when IDLE.
- out_ready while out_valid = 0 is ignored.
- Reset mid-operation: presented and pending events are discarded; no handshake is required after reset.
- Level mode with req held high: the bit re-pends every cycle. A presented event is re-presented after acceptance, and overflow pulses while the bit is pending and req stays high.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined:
  - rr_ptr register records the last accepted index, updated on handshake.
  - Search starts at (rr_ptr+1) mod N and proceeds upward with wrap. The first pending bit found wins.
  - rr_ptr resets to N-1, so the first search starts at index 0.
- Undefined: fixed priority as above. No rr_ptr register exists.

Decomposition:
- Shared package enc_pkg:
  - state enum {IDLE, PRESENT};
  - clog2-safe width function;
  - localparam default N = 8.
- One combinational sub-module enc_prio_pick:
  - inputs: vector N and start offset;
  - outputs: IDX_W index, N-bit one-hot, any flag.
  - Fixed mode ties the offset so the pick reduces to highest-index-wins.

Test Plan:
- Fixed, level, N=8: req=8'b0100_1000 pulsed 1 cycle, out_ready=1 -> out_idx 6 then 3 on consecutive cycles. out_valid drops the cycle after the second handshake. pending = 0.
- Backpressure: pending has bit 2 set, out_ready=0 for 5 cycles -> out_idx=2 and out_valid=1 stable all 5 cycles. Then raise out_ready -> one handshake, IDLE next cycle.
- Overflow: EDGE=1, bit 5 pending and not presented, second rising edge on req[5] -> overflow=1 for exactly one cycle. Bit 5 presented only once.
- Capture-vs-take: req[4] edge in the same cycle bit 4 is loaded to the output -> index 4 presented twice. overflow stays 0.
- ENC_ROUND_ROBIN_EN, req=8'hFF held (level), out_ready=1 -> out_idx sequence 0,1,2,...,7,0. Without the macro -> 7 repeated.
- Async reset: drop rst_n mid-PRESENT between clock edges -> out_valid, pending and overflow are 0 immediately. First event after release needs the full 2-cycle latency.
